// File: rtl/edge_capture_pkg.sv
// Shared definitions for the edge capture unit: register map addresses and
// the constant function giving a counter's saturation value.
package edge_capture_pkg;

    localparam int ADDR_CAPTURE  = 0;
    localparam int ADDR_IRQ_MASK = 1;
    localparam int ADDR_RISE_EN  = 2;
    localparam int ADDR_FALL_EN  = 3;
    localparam int ADDR_CNT_CLR  = 4;

    // Largest value an unsigned counter of the given width can hold.
    function automatic logic [31:0] cnt_saturate(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/edge_capture_unit_if.sv
// Register bus of the edge capture unit: write strobe, address, write and
// read data, the interrupt and done flags, and the counter peek port.
// The master side is the bus decoder, the slave side is the unit itself.
interface edge_capture_unit_if #(
    parameter int NUM_INPUTS = 12,
    parameter int CNT_W      = 8,
    parameter int ADDR_W     = 3
);
    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic                  we;
    logic [ADDR_W-1:0]     register_addr;
    logic [NUM_INPUTS-1:0] wr_data;
    logic [NUM_INPUTS-1:0] rd_data;
    logic                  irq;
    logic                  done;
    logic [SEL_W-1:0]      cnt_sel;
    logic [CNT_W-1:0]      cnt_data;

    modport master (
        output we, register_addr, wr_data, cnt_sel,
        input  rd_data, irq, done, cnt_data
    );

    modport slave (
        input  we, register_addr, wr_data, cnt_sel,
        output rd_data, irq, done, cnt_data
    );
endinterface

// File: rtl/ecu_channel.sv
// One input channel: remembers the previous input level, detects the enabled
// edges, holds the sticky capture bit and a saturating event counter.
module ecu_channel
    import edge_capture_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             primed,
    input  logic             din,
    input  logic             rise_en,
    input  logic             fall_en,
    input  logic             clr_capture,
    input  logic             clr_cnt,
    output logic             capture,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_saturate(CNT_W));

    logic prev;
    logic edge_det;

    // Edge qualification; nothing is reported until the channel has a valid previous level.
    always_comb begin
        edge_det = primed & ((rise_en & din & ~prev) | (fall_en & ~din & prev));
    end

    // Previous level, sticky capture (a new edge beats a clear) and saturating counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= 1'b0;
            capture <= 1'b0;
            cnt     <= '0;
        end else if (enable) begin
            prev    <= din;
            capture <= (capture & ~clr_capture) | edge_det;
            if (clr_cnt) begin
                cnt <= edge_det ? CNT_W'(1) : '0;
            end else if (edge_det && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/edge_capture_unit.sv
// Edge capture unit: per-channel programmable edge detection with sticky
// capture, event counters, a small register file and a masked interrupt.
// Build option ECU_IRQ_PULSE_EN turns the level interrupt into a one-cycle
// pulse on each new masked capture.
module edge_capture_unit
    import edge_capture_pkg::*;
#(
    parameter int NUM_INPUTS = 12,
    parameter int CNT_W      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_INPUTS-1:0] noise_canc,
    edge_capture_unit_if.slave    bus
);
    logic                  primed;
    logic [NUM_INPUTS-1:0] mask;
    logic [NUM_INPUTS-1:0] rise_en;
    logic [NUM_INPUTS-1:0] fall_en;
    logic [NUM_INPUTS-1:0] capture;
    logic [NUM_INPUTS-1:0] clr_capture;
    logic [NUM_INPUTS-1:0] clr_cnt;
    logic [CNT_W-1:0]      cnt_arr [NUM_INPUTS];
    logic                  wr_ok;
    logic                  sel_capture;
    logic                  sel_cnt_clr;
    logic                  done_q;
    logic                  irq_q;

    assign wr_ok       = bus.we & enable;
    assign sel_capture = (bus.register_addr == ADDR_W'(ADDR_CAPTURE));
    assign sel_cnt_clr = (bus.register_addr == ADDR_W'(ADDR_CNT_CLR));
    assign clr_capture = (wr_ok && sel_capture) ? bus.wr_data : '0;
    assign clr_cnt     = (wr_ok && sel_cnt_clr) ? bus.wr_data : '0;

    // The first enabled cycle after reset only loads the previous levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            primed <= 1'b0;
        end else if (enable) begin
            primed <= 1'b1;
        end
    end

    // Read/write configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask    <= '0;
            rise_en <= '1;
            fall_en <= '0;
        end else if (wr_ok) begin
            if (bus.register_addr == ADDR_W'(ADDR_IRQ_MASK)) mask    <= bus.wr_data;
            if (bus.register_addr == ADDR_W'(ADDR_RISE_EN))  rise_en <= bus.wr_data;
            if (bus.register_addr == ADDR_W'(ADDR_FALL_EN))  fall_en <= bus.wr_data;
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        ecu_channel #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .primed      (primed),
            .din         (noise_canc[i]),
            .rise_en     (rise_en[i]),
            .fall_en     (fall_en[i]),
            .clr_capture (clr_capture[i]),
            .clr_cnt     (clr_cnt[i]),
            .capture     (capture[i]),
            .cnt         (cnt_arr[i])
        );
    end

    // Acknowledge every accepted CAPTURE write with a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else if (enable) begin
            done_q <= wr_ok & sel_capture;
        end
    end

`ifdef ECU_IRQ_PULSE_EN
    logic [NUM_INPUTS-1:0] cm_q;

    // Pulse once when any masked capture bit newly turns on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cm_q  <= '0;
            irq_q <= 1'b0;
        end else if (enable) begin
            cm_q  <= capture & mask;
            irq_q <= |((capture & mask) & ~cm_q);
        end
    end
`else
    // Level interrupt: any masked capture bit set in the previous cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (enable) begin
            irq_q <= |(capture & mask);
        end
    end
`endif

    // Combinational register read; CNT_CLR and unmapped addresses read zero.
    always_comb begin
        bus.rd_data = '0;
        if (bus.register_addr == ADDR_W'(ADDR_CAPTURE))  bus.rd_data = capture;
        if (bus.register_addr == ADDR_W'(ADDR_IRQ_MASK)) bus.rd_data = mask;
        if (bus.register_addr == ADDR_W'(ADDR_RISE_EN))  bus.rd_data = rise_en;
        if (bus.register_addr == ADDR_W'(ADDR_FALL_EN))  bus.rd_data = fall_en;
    end

    assign bus.cnt_data = (32'(bus.cnt_sel) < NUM_INPUTS) ? cnt_arr[bus.cnt_sel] : '0;
    assign bus.done     = done_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_edge_capture_unit.sv
// Self-checking bench for edge_capture_unit: a table of directed vectors,
// hand-written corner sequences and randomized traffic against a
// behavioural model. Honours ECU_IRQ_PULSE_EN for the interrupt shape.
module tb_edge_capture_unit;
    import edge_capture_pkg::*;

    localparam int N       = 12;
    localparam int CW      = 8;
    localparam int AW      = 3;
    localparam int SW      = $clog2(N);
    localparam int CNT_MAX = 2 ** CW - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] noise_canc;

    edge_capture_unit_if #(.NUM_INPUTS(N), .CNT_W(CW), .ADDR_W(AW)) bus ();

    edge_capture_unit #(.NUM_INPUTS(N), .CNT_W(CW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .noise_canc (noise_canc),
        .bus        (bus)
    );

    always #50 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [N-1:0] m_cap, m_mask, m_rise, m_fall, m_prev, m_cm_q;
    bit           m_primed, m_done, m_irq;
    int           m_cnt [N];

    typedef struct {
        logic         rst_n;
        logic         en;
        logic         we;
        logic [AW-1:0] addr;
        logic [N-1:0] wdata;
        logic [N-1:0] noise;
        int           sel;
        logic [N-1:0] exp_rd;
        int           exp_cnt;
        logic         exp_done;
        logic         exp_irq;
    } vec_t;

    vec_t vecs [16];

`ifdef ECU_IRQ_PULSE_EN
    localparam logic IRQ_AFTER_CLEAR = 1'b0;
`else
    localparam logic IRQ_AFTER_CLEAR = 1'b1;
`endif

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] modelRead(input int a);
        case (a)
            ADDR_CAPTURE:  return m_cap;
            ADDR_IRQ_MASK: return m_mask;
            ADDR_RISE_EN:  return m_rise;
            ADDR_FALL_EN:  return m_fall;
            default:       return '0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        logic [N-1:0] ev;
        logic [N-1:0] cm;
        bit           wr;
        int           a;
        if (!rst_n) begin
            m_cap = '0; m_mask = '0; m_rise = '1; m_fall = '0;
            m_prev = '0; m_cm_q = '0;
            m_primed = 0; m_done = 0; m_irq = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            return;
        end
        if (!enable) return;
        wr = bus.we;
        a  = int'(bus.register_addr);
        cm = m_cap & m_mask;
`ifdef ECU_IRQ_PULSE_EN
        m_irq  = (cm & ~m_cm_q) != '0;
        m_cm_q = cm;
`else
        m_irq = (cm != '0);
`endif
        m_done = wr && (a == ADDR_CAPTURE);
        for (int i = 0; i < N; i++) begin
            bit rose, fell;
            rose  = (noise_canc[i] == 1'b1) && (m_prev[i] == 1'b0);
            fell  = (noise_canc[i] == 1'b0) && (m_prev[i] == 1'b1);
            ev[i] = m_primed && ((rose && m_rise[i]) || (fell && m_fall[i]));
        end
        for (int i = 0; i < N; i++) begin
            if (wr && a == ADDR_CNT_CLR && bus.wr_data[i]) m_cnt[i] = ev[i] ? 1 : 0;
            else if (ev[i]) m_cnt[i] = (m_cnt[i] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[i] + 1;
        end
        if (wr && a == ADDR_CAPTURE) m_cap = m_cap & ~bus.wr_data;
        m_cap = m_cap | ev;
        if (wr && a == ADDR_IRQ_MASK) m_mask = bus.wr_data;
        if (wr && a == ADDR_RISE_EN)  m_rise = bus.wr_data;
        if (wr && a == ADDR_FALL_EN)  m_fall = bus.wr_data;
        m_prev   = noise_canc;
        m_primed = 1;
    endtask

    // Apply one cycle of inputs, step the model, and land 1 unit after the edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic we,
                                 input logic [AW-1:0] addr, input logic [N-1:0] wd,
                                 input logic [N-1:0] noise, input int sel);
        rst_n             = rst;
        enable            = en;
        bus.we            = we;
        bus.register_addr = addr;
        bus.wr_data       = wd;
        noise_canc        = noise;
        bus.cnt_sel       = SW'(sel);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Compare every readable register, every counter and both flags to the model.
    task automatic checkModel(input string tag);
        logic [AW-1:0] save_addr;
        logic [SW-1:0] save_sel;
        save_addr = bus.register_addr;
        save_sel  = bus.cnt_sel;
        checkOutput($sformatf("%s irq", tag), 32'(bus.irq), 32'(m_irq));
        checkOutput($sformatf("%s done", tag), 32'(bus.done), 32'(m_done));
        for (int a = 0; a < 8; a++) begin
            bus.register_addr = AW'(a);
            #1;
            checkOutput($sformatf("%s rd[%0d]", tag, a), 32'(bus.rd_data), 32'(modelRead(a)));
        end
        for (int s = 0; s < N; s++) begin
            bus.cnt_sel = SW'(s);
            #1;
            checkOutput($sformatf("%s cnt[%0d]", tag, s), 32'(bus.cnt_data), 32'(m_cnt[s]));
        end
        bus.register_addr = save_addr;
        bus.cnt_sel       = save_sel;
        #1;
    endtask

    initial begin
        //           rst  en  we  addr  wdata    noise   sel  exp_rd   cnt done irq
        vecs[0]  = '{1'b0,1'b1,1'b0,3'd0,12'h000,12'h000,0,12'h000,0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,3'd2,12'h000,12'h000,0,12'hFFF,0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,3'd0,12'h000,12'h001,0,12'h001,1,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b1,3'd1,12'h001,12'h001,0,12'h001,1,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b0,3'd0,12'h000,12'h001,0,12'h001,1,1'b0,1'b1};
        vecs[5]  = '{1'b1,1'b1,1'b1,3'd0,12'h001,12'h001,0,12'h000,1,1'b1,IRQ_AFTER_CLEAR};
        vecs[6]  = '{1'b1,1'b1,1'b0,3'd0,12'h000,12'h001,0,12'h000,1,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b1,3'd3,12'h004,12'h001,2,12'h004,0,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b1,3'd2,12'h000,12'h001,2,12'h000,0,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b0,3'd0,12'h000,12'h005,2,12'h000,0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b0,3'd0,12'h000,12'h001,2,12'h004,1,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b1,1'b1,3'd2,12'hFFF,12'h001,3,12'hFFF,0,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b1,3'd0,12'h008,12'h009,3,12'h00C,1,1'b1,1'b0};
        vecs[13] = '{1'b1,1'b1,1'b0,3'd0,12'h000,12'h009,3,12'h00C,1,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b1,1'b1,3'd4,12'h008,12'h001,3,12'h000,0,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b1,1'b1,3'd4,12'h008,12'h009,3,12'h000,1,1'b0,1'b0};

        $display("[TB] directed vector table");
        for (int v = 0; v < 16; v++) begin
            applyStimulus(vecs[v].rst_n, vecs[v].en, vecs[v].we, vecs[v].addr,
                          vecs[v].wdata, vecs[v].noise, vecs[v].sel);
            checkOutput($sformatf("vec%0d rd", v), 32'(bus.rd_data), 32'(vecs[v].exp_rd));
            checkOutput($sformatf("vec%0d cnt", v), 32'(bus.cnt_data), 32'(vecs[v].exp_cnt));
            checkOutput($sformatf("vec%0d done", v), 32'(bus.done), 32'(vecs[v].exp_done));
            checkOutput($sformatf("vec%0d irq", v), 32'(bus.irq), 32'(vecs[v].exp_irq));
        end
        checkModel("post-table");

        $display("[TB] counter saturation on channel 5");
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 12'h029, 5);
            applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 12'h009, 5);
        end
        checkOutput("sat cnt5", 32'(bus.cnt_data), 32'd255);
        checkOutput("sat capture", 32'(bus.rd_data), 32'h02C);
        checkModel("sat");
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd4, 12'h020, 12'h009, 5);
        checkOutput("cnt_clr cnt5", 32'(bus.cnt_data), 32'd0);
        checkModel("cnt_clr");

        $display("[TB] enable low holds all state");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, AW'(k % 5), 12'(~12'h000), N'($urandom), 5);
            checkModel($sformatf("hold%0d", k));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 12'h009, 5);
        checkOutput("hold capture", 32'(bus.rd_data), 32'h02C);
        checkModel("hold exit");

        $display("[TB] reset mid-run and priming cycle");
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 12'h000, 12'hFFF, 0);
        checkOutput("rst capture", 32'(bus.rd_data), 32'h000);
        checkOutput("rst irq", 32'(bus.irq), 32'd0);
        checkOutput("rst done", 32'(bus.done), 32'd0);
        checkOutput("rst cnt0", 32'(bus.cnt_data), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 12'hFFF, 0);
        checkOutput("prime capture", 32'(bus.rd_data), 32'h000);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 12'hFFF, 0);
        checkOutput("post-prime capture", 32'(bus.rd_data), 32'h000);
        checkModel("post-reset");

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            logic         r_rst, r_en, r_we;
            logic [N-1:0] r_noise;
            r_rst   = ($urandom_range(0, 99) != 0);
            r_en    = ($urandom_range(0, 9) != 0);
            r_we    = ($urandom_range(0, 3) == 0);
            r_noise = noise_canc ^ (N'($urandom) & N'($urandom) & N'($urandom));
            applyStimulus(r_rst, r_en, r_we, AW'($urandom_range(0, 7)), N'($urandom),
                          r_noise, $urandom_range(0, N - 1));
            checkModel($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
